hv_efuse_loader: RTL and testbench

- Efuse load engine directly upstream of the HV control FSM.
- Serves the FSM's efuse load request by reading the efuse macro word by word with fixed setup and strobe timing.
- Writes each captured word into the register bank.
- Returns a one-cycle load-done pulse and a level efuse-valid flag, which feed the FSM's load-done and efuse-valid inputs.

---
 rtl/hv_efuse_loader.sv | 201 ++++++++++++++++++++
 tb/tb_hv_efuse_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hv_efuse_loader.sv
// hv_efuse_loader: efuse load engine in front of the HV control FSM.
// On a (rearmed) load request it reads EFUSE_WORD_NUM words from the efuse
// macro with fixed setup/strobe timing. Each word is copied into the register
// bank. The engine then reports load-done and efuse-valid.
// Optional build macro EFUSE_CRC_CHK_EN: the last word is treated as the XOR
// checksum of the others. Valid then also requires that checksum to match.
module hv_efuse_loader #(
    parameter int EFUSE_WORD_NUM = 8,
    parameter int EFUSE_DATA_W   = 8,
    parameter int EFUSE_ADDR_W   = 3,
    parameter int SETUP_CYC      = 2,
    parameter int RD_PULSE_CYC   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_efuse_load_req,
    output logic                    o_efuse_load_done,
    output logic                    o_efuse_vld,
    output logic                    o_efuse_crc_err,
    output logic                    o_efuse_busy,
    output logic                    o_efuse_rd_en,
    output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
    input  logic [EFUSE_DATA_W-1:0] i_efuse_rdata,
    output logic                    o_efuse_reg_wr_en,
    output logic [EFUSE_ADDR_W-1:0] o_efuse_reg_waddr,
    output logic [EFUSE_DATA_W-1:0] o_efuse_reg_wdata
);

    localparam int MAX_CYC = (SETUP_CYC > RD_PULSE_CYC) ? SETUP_CYC : RD_PULSE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0]        SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]        STROBE_LAST = CNT_W'(RD_PULSE_CYC - 1);
    localparam logic [EFUSE_ADDR_W-1:0] LAST_IDX    = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_CAPTURE,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [EFUSE_ADDR_W-1:0] idx_q, idx_d;
    logic                    rearm_q, rearm_d;
    logic                    marker_q, marker_d;
    logic [EFUSE_DATA_W-1:0] data_q;
    logic                    cap;
    logic                    vld_d;
    logic                    result_vld;

    // State, timing counter, word index, rearm and programmed-marker registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            rearm_q  <= 1'b1;
            marker_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rearm_q  <= rearm_d;
            marker_q <= marker_d;
        end
    end

    // Next-state logic; outputs are registered from these next values, so
    // every output changes on the same edge that enters the matching state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rearm_d  = rearm_q;
        marker_d = marker_q;
        vld_d    = o_efuse_vld;
        cap      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!i_efuse_load_req) begin
                    rearm_d = 1'b1;
                end else if (rearm_q) begin
                    state_d  = S_SETUP;
                    idx_d    = '0;
                    cnt_d    = '0;
                    vld_d    = 1'b0;
                    marker_d = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    // read data is sampled while the strobe is still high
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                    cap     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (idx_q == '0) marker_d = data_q[EFUSE_DATA_W-1];
                if (idx_q == LAST_IDX) begin
                    state_d = S_CHECK;
                end else begin
                    idx_d   = idx_q + EFUSE_ADDR_W'(1);
                    state_d = S_SETUP;
                end
            end
            S_CHECK: begin
                state_d = S_DONE;
                vld_d   = result_vld;
            end
            S_DONE: begin
                // a held request must drop before another load is accepted
                rearm_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Captured efuse word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)    data_q <= '0;
        else if (cap) data_q <= i_efuse_rdata;
    end

    // Registered outputs, decoded from the next state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_efuse_rd_en     <= 1'b0;
            o_efuse_reg_wr_en <= 1'b0;
            o_efuse_busy      <= 1'b0;
            o_efuse_load_done <= 1'b0;
            o_efuse_vld       <= 1'b0;
            o_efuse_addr      <= '0;
            o_efuse_reg_waddr <= '0;
            o_efuse_reg_wdata <= '0;
        end else begin
            o_efuse_rd_en     <= (state_d == S_STROBE);
            o_efuse_reg_wr_en <= (state_d == S_WRITE);
            o_efuse_busy      <= (state_d != S_IDLE);
            o_efuse_load_done <= (state_d == S_DONE);
            o_efuse_vld       <= vld_d;
            o_efuse_addr      <= idx_d;
            if (state_d == S_WRITE) begin
                o_efuse_reg_waddr <= idx_d;
                o_efuse_reg_wdata <= data_q;
            end
        end
    end

`ifdef EFUSE_CRC_CHK_EN
    logic [EFUSE_DATA_W-1:0] acc_q;
    logic                    load_start;

    assign load_start = (state_q == S_IDLE) && i_efuse_load_req && rearm_q;
    // during CHECK data_q still holds the last word, i.e. the stored checksum
    assign result_vld = marker_q & (acc_q == data_q);

    // XOR accumulator over every word except the checksum word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            acc_q <= '0;
        else if (load_start)
            acc_q <= '0;
        else if ((state_q == S_WRITE) && (idx_q != LAST_IDX))
            acc_q <= acc_q ^ data_q;
    end

    // Checksum error flag, cleared at load start, updated together with vld
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_efuse_crc_err <= 1'b0;
        else if (load_start)
            o_efuse_crc_err <= 1'b0;
        else if (state_q == S_CHECK)
            o_efuse_crc_err <= marker_q & (acc_q != data_q);
    end
`else
    assign result_vld      = marker_q;
    assign o_efuse_crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_hv_efuse_loader.sv
// Directed bench for hv_efuse_loader: a table of efuse images with expected
// vld/crc_err, plus sequences for held request, mid-load drop and reset.
module tb_hv_efuse_loader;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int AW = 3;
`ifdef EFUSE_CRC_CHK_EN
    localparam bit CRC = 1'b1;
`else
    localparam bit CRC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          done, vld, crc_err, busy, rd_en, wr_en;
    logic [AW-1:0] addr, waddr;
    logic [W-1:0]  rdata, wdata;

    // efuse macro model: word k at bits [8k+7:8k]; inverted data off-strobe
    logic [N-1:0][W-1:0] mem = '0;
    assign rdata = rd_en ? mem[addr] : ~mem[addr];

    hv_efuse_loader dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_efuse_load_req (req),
        .o_efuse_load_done(done),
        .o_efuse_vld      (vld),
        .o_efuse_crc_err  (crc_err),
        .o_efuse_busy     (busy),
        .o_efuse_rd_en    (rd_en),
        .o_efuse_addr     (addr),
        .i_efuse_rdata    (rdata),
        .o_efuse_reg_wr_en(wr_en),
        .o_efuse_reg_waddr(waddr),
        .o_efuse_reg_wdata(wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // monitor state (sampled on the falling edge)
    logic [AW-1:0] wq_addr[$];
    logic [W-1:0]  wq_data[$];
    int done_cnt = 0, done_cyc = 0, done_bad = 0;
    int n_rise = 0, setup_bad = 0, rd_bad = 0, wr_bad = 0;
    int stable = 0, rd_len = 0;
    logic prev_rd = 0, prev_wr = 0, prev_done = 0, prev_busy = 0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(waddr);
            wq_data.push_back(wdata);
            if (prev_wr) wr_bad++;
        end
        if (done) begin
            if (!prev_done) done_cyc = cyc;
            else            done_bad++;
            done_cnt++;
        end
        if (rd_en) begin
            if (!prev_rd) begin
                n_rise++;
                if (stable != 2) setup_bad++;
                rd_len = 0;
            end else if (addr != prev_addr) begin
                rd_bad++;
            end
            rd_len++;
            stable = 0;
        end else begin
            if (prev_rd && rd_len != 4) rd_bad++;
            if (busy && prev_busy && addr == prev_addr) stable++;
            else stable = busy ? 1 : 0;
        end
        prev_rd   = rd_en;
        prev_wr   = wr_en;
        prev_done = done;
        prev_busy = busy;
        prev_addr = addr;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        n_rise = 0; setup_bad = 0; rd_bad = 0; wr_bad = 0; done_bad = 0;
        stable = 0;
    endtask

    // wait for the done pulse after a load was launched with req sampled in
    // the cycle whose counter value was c_set; check timing, writes, flags
    task automatic finish_load(input string name, input logic [N-1:0][W-1:0] img,
                               input logic exp_vld, input logic exp_err,
                               input int c_set, input int start_cnt, input int drop_word);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (drop_word >= 0 && busy && addr == AW'(drop_word)) req = 1'b0;
            if (done_cnt > start_cnt) begin seen = 1; break; end
        end
        chk({name, " done seen"}, 64'(seen), 64'd1);
        chk({name, " done latency"}, 64'(done_cyc - c_set), 64'd66);
        chk({name, " vld"}, 64'(vld), 64'(exp_vld));
        chk({name, " crc_err"}, 64'(crc_err), 64'(exp_err));
        chk({name, " write count"}, 64'(wq_addr.size()), 64'(N));
        for (int k = 0; k < N && k < wq_addr.size(); k++) begin
            chk($sformatf("%s waddr %0d", name, k), 64'(wq_addr[k]), 64'(k));
            chk($sformatf("%s wdata %0d", name, k), 64'(wq_data[k]), 64'(img[k]));
        end
        chk({name, " strobe count"}, 64'(n_rise), 64'(N));
        chk({name, " setup timing"}, 64'(setup_bad), 64'd0);
        chk({name, " strobe width"}, 64'(rd_bad), 64'd0);
        chk({name, " wr pulse width"}, 64'(wr_bad), 64'd0);
        chk({name, " done pulse width"}, 64'(done_bad), 64'd0);
    endtask

    task automatic run_load(input string name, input logic [N-1:0][W-1:0] img,
                            input logic exp_vld, input logic exp_err, input int drop_word);
        int c_set, start_cnt;
        mem = img;
        req = 1'b0;
        tick(2);
        clear_mon();
        start_cnt = done_cnt;
        req = 1'b1;
        c_set = cyc;
        finish_load(name, img, exp_vld, exp_err, c_set, start_cnt, drop_word);
    endtask

    typedef struct {
        string               name;
        logic [N-1:0][W-1:0] img;
        logic                vld;
        logic                err;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int  c_set, start_cnt;
        bit  any_busy, seen;

        // word 0 is the least significant byte of each image
        tbl[0] = '{"basic",   64'h77_66_55_44_33_22_11_80, !CRC, CRC};
        tbl[1] = '{"unprog",  64'h00_00_00_00_00_00_00_00, 1'b0, 1'b0};
        tbl[2] = '{"crc_ok",  64'hBF_20_10_08_04_02_01_80, 1'b1, 1'b0};
        tbl[3] = '{"crc_bad", 64'hBE_20_10_08_04_02_01_80, !CRC, CRC};
        tbl[4] = '{"nomark",  64'h3F_20_10_08_04_02_01_00, 1'b0, 1'b0};

        tick(3);
        chk("rst done",    64'(done),    64'd0);
        chk("rst vld",     64'(vld),     64'd0);
        chk("rst crc_err", 64'(crc_err), 64'd0);
        chk("rst busy",    64'(busy),    64'd0);
        chk("rst rd_en",   64'(rd_en),   64'd0);
        chk("rst addr",    64'(addr),    64'd0);
        chk("rst wr_en",   64'(wr_en),   64'd0);
        chk("rst waddr",   64'(waddr),   64'd0);
        chk("rst wdata",   64'(wdata),   64'd0);
        rst = 1'b0;
        tick(2);

        for (int v = 0; v < 5; v++)
            run_load(tbl[v].name, tbl[v].img, tbl[v].vld, tbl[v].err, -1);

        // request held high after done must not start another load
        any_busy = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            any_busy |= busy;
        end
        chk("held req no restart", 64'(any_busy), 64'd0);
        chk("held req vld kept", 64'(vld), 64'd0);

        // low then high again starts a fresh load
        run_load("rearm", tbl[0].img, tbl[0].vld, tbl[0].err, -1);

        // request dropped during word 3: load still completes
        run_load("drop_w3", tbl[2].img, tbl[2].vld, tbl[2].err, 3);

        // reset during the strobe of word 5
        mem = tbl[2].img;
        req = 1'b0;
        tick(2);
        req = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (rd_en && addr == AW'(5)) begin seen = 1; break; end
        end
        chk("reach word5 strobe", 64'(seen), 64'd1);
        start_cnt = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst rd_en", 64'(rd_en), 64'd0);
        chk("mid rst wr_en", 64'(wr_en), 64'd0);
        chk("mid rst busy",  64'(busy),  64'd0);
        chk("mid rst vld",   64'(vld),   64'd0);
        tick(3);
        chk("mid rst no done", 64'(done_cnt - start_cnt), 64'd0);
        clear_mon();
        rst = 1'b0;
        c_set = cyc;
        finish_load("after_rst", tbl[2].img, tbl[2].vld, tbl[2].err, c_set, start_cnt, -1);

        req = 1'b0;
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
